// File: rtl/adding_machine_fetch_pkg.sv
// Shared types and constants for the adding-machine operand-fetch stage.
// Holds the fetch FSM encoding, word-address width and default sizing.
package adding_machine_fetch_pkg;

    localparam int WADDR_W   = 30;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_DRAIN = 2'b10
    } fetch_state_t;

    // Word-address increment; wraps from all-ones back to zero.
    function automatic logic [WADDR_W-1:0] adder30(input logic [WADDR_W-1:0] a);
        return a + 30'd1;
    endfunction

endpackage

// File: rtl/adding_machine_fetch_sync_fifo.sv
// Synchronous FIFO with registered storage and occupancy; head is the oldest entry.
// Pushes into a full FIFO and pops from an empty FIFO are dropped.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (level_r == LVL_W'(DEPTH));
    assign empty     = (level_r == {LVL_W{1'b0}});
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign head      = mem_r[rd_ptr_r];
    assign level     = level_r;

    // Entry storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/adding_machine_fetch.sv
// Operand-fetch stage: walks a word memory for a bounded burst, buffers words in a
// FIFO and streams them downstream over valid/ready, pulsing done when drained.
module adding_machine_fetch
    import adding_machine_fetch_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:2]      base,
    input  logic [CNT_W-1:0] count,
    output logic [31:2]      mem_addr,
    input  logic [31:0]      mem_data,
    output logic [31:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);

    fetch_state_t       state_r, state_s;
    logic [WADDR_W-1:0] addr_r, addr_s;
    logic [CNT_W-1:0]   remaining_r, remaining_s;
    logic               done_r, done_s;
    logic               busy_r;
    logic               push_s;
    logic               pop_s;
    logic               full_s;
    logic               empty_s;
    logic [LVL_W-1:0]   level_s;
    logic [31:0]        head_s;

    assign pop_s     = !empty_s && out_ready;
    assign mem_addr  = addr_r;
    assign out_data  = head_s;
    assign out_valid = !empty_s;
    assign busy      = busy_r;
    assign done      = done_r;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (push_s),
        .push_data (mem_data),
        .pop       (pop_s),
        .head      (head_s),
        .full      (full_s),
        .empty     (empty_s),
        .level     (level_s)
    );

    // Next-state, counter updates and push/done decisions
    always_comb begin
        state_s     = state_r;
        addr_s      = addr_r;
        remaining_s = remaining_r;
        push_s      = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    addr_s      = base;
                    remaining_s = count;
                    if (count == CNT_ZERO) begin
                        state_s = ST_DRAIN;
                    end else begin
                        state_s = ST_FETCH;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                // Full is judged on registered occupancy, so a same-cycle pop never frees a slot.
                if (remaining_r == CNT_ZERO) begin
                    state_s = ST_DRAIN;
                end else if (!full_s) begin
                    push_s      = 1'b1;
                    addr_s      = adder30(addr_r);
                    remaining_s = remaining_r - CNT_ONE;
                    if (remaining_r == CNT_ONE) begin
                        state_s = ST_DRAIN;
                    end else begin
                        state_s = ST_FETCH;
                    end
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                // done is raised the cycle the FIFO goes empty; the FSM leaves DRAIN after that pulse.
                done_s = !done_r && (empty_s || (level_s == LVL_ONE && pop_s));
                if (empty_s && done_r) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Control and status registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            addr_r      <= {WADDR_W{1'b0}};
            remaining_r <= CNT_ZERO;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            addr_r      <= addr_s;
            remaining_r <= remaining_s;
            done_r      <= done_s;
            busy_r      <= (state_s != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_adding_machine_fetch.sv
// Directed bench for adding_machine_fetch: table of bursts plus reset-state and
// reset-mid-burst sequences, with a combinational memory returning 0x100 + address.
module tb_adding_machine_fetch;

    logic        clk;
    logic        reset;
    logic        start;
    logic [29:0] base;
    logic [15:0] count;
    logic [29:0] mem_addr;
    logic [31:0] mem_data;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic [29:0] base;
        logic [15:0] count;
        int          hold;
        int          rs_cyc;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
        int          exp_fv;
        int          exp_done;
        int          chk_cyc;
        logic [29:0] exp_addr;
    } vec_t;

    vec_t vecs[6];

    adding_machine_fetch #(.DEPTH(4), .CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base      (base),
        .count     (count),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    assign mem_data = 32'h100 + {2'b00, mem_addr};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Start one burst and observe it cycle by cycle (cycle 1 = first cycle after acceptance).
    task automatic run_burst(input vec_t v);
        int words = 0;
        int dcnt = 0;
        int dcyc = 0;
        int fv = 0;
        logic [29:0] a;
        @(posedge clk);
        #1;
        base      = v.base;
        count     = v.count;
        start     = 1'b1;
        out_ready = (v.hold == 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= v.exp_done + 3; c++) begin
            @(negedge clk);
            out_ready = (c > v.hold);
            if (c == v.rs_cyc) begin
                start = 1'b1;
                base  = 30'h140;
                count = 16'd9;
            end else begin
                start = 1'b0;
            end
            if (c == v.chk_cyc) check("mem_addr", {2'b00, mem_addr}, {2'b00, v.exp_addr});
            if (out_valid && fv == 0) fv = c;
            if (out_valid && out_ready) begin
                a = v.base + 30'(words);
                check("word", out_data, 32'h100 + {2'b00, a});
                if (words == 0) check("first_word", out_data, v.exp_first);
                if (words == int'(v.count) - 1) check("last_word", out_data, v.exp_last);
                words++;
            end
            if (done) begin
                dcnt++;
                dcyc = c;
            end
            if (c == v.exp_done) check("busy_at_done", {31'd0, busy}, 32'd1);
            if (c == v.exp_done + 1) check("busy_after_done", {31'd0, busy}, 32'd0);
        end
        start = 1'b0;
        check("word_count", 32'(words), {16'd0, v.count});
        check("first_valid_cycle", 32'(fv), 32'(v.exp_fv));
        check("done_pulses", 32'(dcnt), 32'd1);
        check("done_cycle", 32'(dcyc), 32'(v.exp_done));
    endtask

    initial begin
        int pops;
        //          base           count  hold rs  first         last          fv done chk addr
        vecs[0] = '{30'h10,        16'd3, 0,   0,  32'h110,      32'h112,      2, 5,   1,  30'h10};
        vecs[1] = '{30'h200,       16'd1, 0,   0,  32'h300,      32'h300,      2, 3,   2,  30'h201};
        vecs[2] = '{30'h40,        16'd8, 10,  0,  32'h140,      32'h147,      2, 19,  8,  30'h44};
        vecs[3] = '{30'h77,        16'd0, 0,   0,  32'h0,        32'h0,        0, 2,   1,  30'h77};
        vecs[4] = '{30'h3FFFFFFE,  16'd4, 0,   0,  32'h400000FE, 32'h101,      2, 6,   3,  30'h0};
        vecs[5] = '{30'h20,        16'd4, 0,   2,  32'h120,      32'h123,      2, 6,   3,  30'h22};

        reset     = 1'b0;
        start     = 1'b0;
        base      = 30'h0;
        count     = 16'd0;
        out_ready = 1'b0;
        #23;
        check("rst_mem_addr", {2'b00, mem_addr}, 32'h0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_burst(vecs[i]);
        end

        // Reset after two of six words have been consumed.
        @(posedge clk);
        #1;
        base      = 30'h60;
        count     = 16'd6;
        start     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        pops  = 0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) pops++;
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_pops", 32'(pops), 32'd2);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_mem_addr", {2'b00, mem_addr}, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("midrst_no_done", {31'd0, done}, 32'd0);
        end
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("post_rst_idle_done", {31'd0, done}, 32'd0);
            check("post_rst_idle_busy", {31'd0, busy}, 32'd0);
        end
        run_burst(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/adding_machine_fetch.md
# adding_machine_fetch

Upstream operand-fetch stage for the pipelined adding machine. Given a word base address and a word count, it walks a combinational-read word memory, buffers fetched words in a small FIFO, and streams them to the accumulate stage over a valid/ready handshake. This replaces the free-running index counter with a bounded, stallable burst that signals completion.

## Interface
- DEPTH, 4, FIFO entries; power of two, at least 2
- CNT_W, 16, width of the burst word count
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low; clears all state
- start  input  1  one-cycle request to begin a burst; sampled only in IDLE
- base  input  [31:2]  word address of the first operand; latched on an accepted start
- count  input  CNT_W  number of words in the burst; latched on an accepted start
- mem_addr  output  [31:2]  word address presented to memory
- mem_data  input  32  combinational read data for mem_addr
- out_data  output  32  head of the FIFO
- out_valid  output  1  FIFO not empty
- out_ready  input  1  downstream accepts out_data this cycle
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse when the last word has been consumed

## Operation
- States: IDLE, FETCH, DRAIN. Reset value is IDLE. All outputs reset to 0: mem_addr = 0, out_valid = 0, busy = 0, done = 0, FIFO empty.
- IDLE: when start = 1, latch addr = base and remaining = count, then go to FETCH. If count = 0, go directly to DRAIN, which completes immediately. start is ignored in every other state.
- FETCH: mem_addr = addr.
  - If the FIFO is not full, push mem_data at the clock edge, increment addr, and decrement remaining.
  - When the push that makes remaining reach 0 occurs, go to DRAIN.
  - If the FIFO is full, issue nothing and leave addr unchanged. A pop in the same cycle does not free a slot for a push, so the full test uses the registered occupancy.
- DRAIN: no pushes. When the FIFO is empty, pulse done for one cycle and return to IDLE. busy is high in FETCH and DRAIN.
- Pop: occurs at the clock edge when out_valid and out_ready are both 1. out_data is the oldest entry.
- A push and a pop in the same cycle are legal when the FIFO is non-empty and not full; occupancy is then unchanged.
- Arithmetic:
  - addr increments modulo 2^30 and wraps from 30'h3FFFFFFF to 0.
  - remaining is CNT_W bits and never underflows.
  - Occupancy is log2(DEPTH)+1 bits.
- Reset mid-burst (asynchronous): FIFO flushed, state IDLE, and the partially delivered burst is abandoned. No done pulse.

## Timing
- Start accepted at edge N. Then:
  - FETCH begins in cycle N+1 with mem_addr = base.
  - The first word is pushed at edge N+1.
  - out_valid = 1 from cycle N+2.
- With out_ready held at 1 and no stalls, one word is delivered per cycle. For count = k, the last word is popped at edge N+k+1, done = 1 in cycle N+k+2, and state is IDLE from cycle N+k+3.
- For count = 0, done = 1 in cycle N+2.
- out_data and out_valid are driven from registers; there is no combinational path from out_ready to out_valid or out_data.
- mem_addr is a registered value. The memory read must settle within the cycle.

## Structure
- A shared package holds:
  - the state enum (IDLE, FETCH, DRAIN)
  - the word-address width constant (30)
  - the default DEPTH and CNT_W
- One sub-module is natural: `sync_fifo`, parameterised by width and depth, with push, pop, full, empty, and head. The fetch control and address/remaining counters stay in the top level, using the existing register and adder30 blocks.

## Test plan
- Basic burst: base = 30'h10, count = 3, out_ready = 1, memory word i = 0x100 + i.
  - out_data sequence is 0x110, 0x111, 0x112 in cycles N+2..N+4.
  - done pulses in cycle N+5; busy falls afterwards.
- Backpressure: count = 8, DEPTH = 4, out_ready = 0 for 10 cycles, then 1.
  - The FIFO fills to 4 and mem_addr holds at base+4.
  - All 8 words are delivered in order with none lost or duplicated.
  - done fires exactly once.
- Zero count: start with count = 0.
  - No push, out_valid stays 0, done = 1 in cycle N+2.
- Wrap: base = 30'h3FFFFFFE, count = 4.
  - mem_addr goes 3FFFFFFE, 3FFFFFFF, 0, 1.
- Start ignored: pulse start again mid-burst with different base and count.
  - The burst is unaffected and a single done is produced.
- Reset mid-burst: assert reset (low) after 2 of 6 words have been popped.
  - out_valid = 0, busy = 0, mem_addr = 0 immediately, with no done pulse.
  - A new start after release runs a clean burst.
